// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizing for the CDB arbiter and its per-FU result FIFOs.
package cdb_arbiter_pkg;

    localparam int N_WAY     = 2;
    localparam int CDB_BITS  = 6;
    localparam int N_FU      = 4;
    localparam int N_CDB     = N_WAY;
    localparam int TAG_W     = CDB_BITS;
    localparam int XLEN      = 32;
    localparam int BUF_DEPTH = 2;
    localparam int FU_W      = (N_FU > 1) ? $clog2(N_FU) : 1;
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
        logic [FU_W-1:0]  fu;
    } CDB_PACKET;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } FU_RESULT;

    // Modulo-N_FU index used by the round-robin scan.
    function automatic logic [FU_W-1:0] fu_wrap(input int idx);
        return FU_W'(idx % N_FU);
    endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-FU holding FIFO for completed results; full/empty are resolved by count.
module cdb_result_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       enq,
    input  logic [TAG_W-1:0]           enq_tag,
    input  logic [XLEN-1:0]            enq_data,
    input  logic                       deq,
    output FU_RESULT                   head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic [XLEN-1:0]  data_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (int'(p) == DEPTH - 1) return '0;
        return p + PTR_W'(1);
    endfunction

    // Storage carries no reset; validity comes from count alone.
    always_ff @(posedge clock) begin
        if (enq && !flush) begin
            tag_mem[wr_ptr]  <= enq_tag;
            data_mem[wr_ptr] <= enq_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= ptr_inc(wr_ptr);
            if (deq) rd_ptr <= ptr_inc(rd_ptr);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        head.valid = (count != '0);
        head.tag   = tag_mem[rd_ptr];
        head.data  = data_mem[rd_ptr];
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing N_CDB registered broadcast slots among N_FU result FIFOs.
// Optional CDB_ARB_STATS_EN adds saturating stall_cycles / bcast_count counters.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [N_FU-1:0]                  fu_valid,
    input  logic [N_FU-1:0][TAG_W-1:0]       fu_tag,
    input  logic [N_FU-1:0][XLEN-1:0]        fu_data,
    output logic [N_FU-1:0]                  fu_ready,
    output logic [N_CDB-1:0]                 cdb_valid,
    output logic [N_CDB-1:0][TAG_W-1:0]      cdb_tag,
    output logic [N_CDB-1:0][XLEN-1:0]       cdb_data,
    output logic [N_CDB-1:0][FU_W-1:0]       cdb_fu,
    output logic [N_FU-1:0][CNT_W-1:0]       buf_count
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [31:0]                      stall_cycles,
    output logic [31:0]                      bcast_count
`endif
);

    FU_RESULT          head [N_FU];
    logic [N_FU-1:0]   enq;
    logic [N_FU-1:0]   deq;
    logic [N_FU-1:0]   nonempty;
    logic [N_FU-1:0]   grant;
    logic [FU_W-1:0]   rr_ptr;
    logic [FU_W-1:0]   last_fu;
    logic [FU_W-1:0]   scan_idx;
    int                n_grant;
    CDB_PACKET         slot_pkt [N_CDB];
    CDB_PACKET         out_p0   [N_CDB];

    // Ready depends only on registered occupancy, never on this cycle's dequeue.
    for (genvar i = 0; i < N_FU; i++) begin : g_fifo
        assign fu_ready[i] = (buf_count[i] < CNT_W'(BUF_DEPTH));
        assign enq[i]      = fu_valid[i] & fu_ready[i] & (fu_tag[i] != '0) & ~flush;
        assign deq[i]      = grant[i] & ~flush;
        assign nonempty[i] = head[i].valid;

        cdb_result_fifo #(
            .DEPTH    (BUF_DEPTH)
        ) u_fifo (
            .clock    (clock),
            .reset    (reset),
            .flush    (flush),
            .enq      (enq[i]),
            .enq_tag  (fu_tag[i]),
            .enq_data (fu_data[i]),
            .deq      (deq[i]),
            .head     (head[i]),
            .count    (buf_count[i])
        );
    end

    // Scan from rr_ptr; the g-th non-empty FIFO found fills slot g.
    always_comb begin
        grant    = '0;
        n_grant  = 0;
        last_fu  = '0;
        scan_idx = '0;
        for (int g = 0; g < N_CDB; g++) slot_pkt[g] = '0;
        for (int j = 0; j < N_FU; j++) begin
            scan_idx = fu_wrap(int'(rr_ptr) + j);
            if (nonempty[scan_idx] && (n_grant < N_CDB)) begin
                for (int g = 0; g < N_CDB; g++) begin
                    if (g == n_grant) begin
                        slot_pkt[g].valid = 1'b1;
                        slot_pkt[g].tag   = head[scan_idx].tag;
                        slot_pkt[g].data  = head[scan_idx].data;
                        slot_pkt[g].fu    = scan_idx;
                    end
                end
                grant[scan_idx] = 1'b1;
                last_fu         = scan_idx;
                n_grant         = n_grant + 1;
            end
        end
    end

    // ---- stage p0: registered CDB slots and round-robin pointer ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int g = 0; g < N_CDB; g++) out_p0[g] <= '0;
            rr_ptr <= '0;
        end else if (flush) begin
            for (int g = 0; g < N_CDB; g++) out_p0[g] <= '0;
        end else begin
            for (int g = 0; g < N_CDB; g++) out_p0[g] <= slot_pkt[g];
            if (grant != '0) rr_ptr <= fu_wrap(int'(last_fu) + 1);
        end
    end

    always_comb begin
        for (int g = 0; g < N_CDB; g++) begin
            cdb_valid[g] = out_p0[g].valid;
            cdb_tag[g]   = out_p0[g].tag;
            cdb_data[g]  = out_p0[g].data;
            cdb_fu[g]    = out_p0[g].fu;
        end
    end

`ifdef CDB_ARB_STATS_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    function automatic logic [31:0] popcount(input logic [N_CDB-1:0] v);
        logic [31:0] c;
        c = '0;
        for (int g = 0; g < N_CDB; g++) c = c + {31'd0, v[g]};
        return c;
    endfunction

    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            bcast_count  <= '0;
        end else begin
            if ((fu_valid & ~fu_ready) != '0) stall_cycles <= sat_add(stall_cycles, 32'd1);
            bcast_count <= sat_add(bcast_count, popcount(cdb_valid));
        end
    end
`endif

endmodule
